sub_seq16: RTL and testbench

SUB_SEQ16 -- requirements
Module: sub_seq16

---
 rtl/sub_seq16_if.sv | 25 ++
 rtl/sub_seq16.sv | 128 ++++++++++++
 tb/tb_sub_seq16.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sub_seq16_if.sv
// Handshake and data bus of the sequential 8/16-bit subtractor.
// The master drives the operation request and operands; the slave (the
// subtractor) returns busy/done, the difference and the 8085-style flags.
interface sub_seq16_if;
    logic        iStart;
    logic        iWide;
    logic        iUseB;
    logic        iCY;
    logic [15:0] iJ;
    logic [15:0] iK;
    logic        oBusy;
    logic        oDone;
    logic [15:0] oD;
    logic [7:0]  oF;

    modport master (
        output iStart, iWide, iUseB, iCY, iJ, iK,
        input  oBusy, oDone, oD, oF
    );

    modport slave (
        input  iStart, iWide, iUseB, iCY, iJ, iK,
        output oBusy, oDone, oD, oF
    );
endinterface

// File: rtl/sub_seq16.sv
// Byte-serial subtractor: SUB/SBB on one byte or DSUB on two bytes, one
// byte per clock, with 8085 flag layout {S,Z,0,AC,0,P,1,CY}.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for iStart; operands and borrow-in latched on start
// LO    | low byte difference, borrow-out and bit-3 borrow stored
// HI    | high byte difference, chained from the low-byte borrow (16-bit)
// FIN   | flags computed from the final byte, oDone pulsed
module sub_seq16 #(
    parameter int NBYTES = 2
) (
    input  logic         iClock,
    input  logic         iReset,
    sub_seq16_if.slave   bus
);
    localparam int DW = 8 * NBYTES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_j;
    logic [DW-1:0] r_k;
    logic [DW-1:0] r_d;
    logic          r_wide;
    logic          r_bin;
    logic          r_cy;
    logic          r_ac;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    r_f;

    logic [7:0]    w_a;
    logic [7:0]    w_b;
    logic          w_bin;
    logic [8:0]    w_full;
    logic [4:0]    w_nib;
    logic [7:0]    w_diff;
    logic          w_bout;
    logic          w_ac;
    logic [7:0]    w_fbyte;
    logic          w_s;
    logic          w_z;
    logic          w_p;

    // One shared byte subtractor; the state picks which operand byte and
    // which borrow-in feed it (HI chains the stored low-byte borrow).
    always_comb begin
        w_a     = (r_state == S_HI) ? r_j[15:8] : r_j[7:0];
        w_b     = (r_state == S_HI) ? r_k[15:8] : r_k[7:0];
        w_bin   = (r_state == S_HI) ? r_cy : r_bin;
        w_full  = {1'b0, w_a} - {1'b0, w_b} - {8'd0, w_bin};
        w_nib   = {1'b0, w_a[3:0]} - {1'b0, w_b[3:0]} - {4'd0, w_bin};
        w_diff  = w_full[7:0];
        w_bout  = w_full[8];
        w_ac    = w_nib[4];
        w_fbyte = r_wide ? r_d[15:8] : r_d[7:0];
        w_s     = w_fbyte[7];
        w_z     = r_wide ? (r_d == '0) : (r_d[7:0] == 8'h00);
        w_p     = ~^w_fbyte;
    end

    // Sequencer with registered busy/done/result/flags; reset aborts any
    // operation and leaves the flags at their reset value.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state <= S_IDLE;
            r_j     <= '0;
            r_k     <= '0;
            r_d     <= '0;
            r_wide  <= 1'b0;
            r_bin   <= 1'b0;
            r_cy    <= 1'b0;
            r_ac    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_f     <= 8'h02;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.iStart) begin
                        r_j     <= bus.iJ;
                        r_k     <= bus.iK;
                        r_wide  <= bus.iWide;
                        r_bin   <= bus.iUseB & bus.iCY;
                        r_busy  <= 1'b1;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    r_d[7:0] <= w_diff;
                    if (!r_wide) begin
                        r_d[15:8] <= 8'h00;
                    end
                    r_cy    <= w_bout;
                    r_ac    <= w_ac;
                    r_state <= r_wide ? S_HI : S_FIN;
                end
                S_HI: begin
                    r_d[15:8] <= w_diff;
                    r_cy      <= w_bout;
                    r_ac      <= w_ac;
                    r_state   <= S_FIN;
                end
                S_FIN: begin
                    r_f     <= {w_s, w_z, 1'b0, r_ac, 1'b0, w_p, 1'b1, r_cy};
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oBusy = r_busy;
    assign bus.oDone = r_done;
    assign bus.oD    = r_d;
    assign bus.oF    = r_f;
endmodule

// File: tb/tb_sub_seq16.sv
// Bench for sub_seq16: directed vectors, protocol cases and random
// operations checked against an arithmetic reference model.
module tb_sub_seq16;
    logic iClock;
    logic iReset;
    int   n_tests;
    int   n_fail;

    sub_seq16_if bus ();

    sub_seq16 #(.NBYTES(2)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands; returns {D, F}.
    function automatic logic [23:0] model(input logic wide, input logic bin,
                                          input logic [15:0] j, input logic [15:0] k);
        int         lo;
        int         res;
        logic       cy;
        logic       ac;
        logic       z;
        logic [15:0] d;
        logic [7:0] fb;
        lo = int'(j[7:0]) - int'(k[7:0]) - int'(bin);
        if (!wide) begin
            d  = 16'(lo & 255);
            cy = (lo < 0);
            ac = ((int'(j[3:0]) - int'(k[3:0]) - int'(bin)) < 0);
            fb = d[7:0];
            z  = (d[7:0] == 8'h00);
        end else begin
            res = int'(j) - int'(k) - int'(bin);
            d   = 16'(res & 65535);
            cy  = (res < 0);
            ac  = ((int'(j[11:8]) - int'(k[11:8]) - ((lo < 0) ? 1 : 0)) < 0);
            fb  = d[15:8];
            z   = (d == 16'h0000);
        end
        return {d, fb[7], z, 1'b0, ac, 1'b0, ~^fb, 1'b1, cy};
    endfunction

    // Issue one operation starting now (just after an edge), optionally
    // poking iStart and garbage operands while busy; returns just after
    // the edge that raises oDone, with iStart low.
    task automatic run_op(input string tag, input logic wide, input logic useb,
                          input logic cy, input logic [15:0] j, input logic [15:0] k,
                          input logic poke);
        logic [23:0] exp;
        int          lat;
        exp = model(wide, useb & cy, j, k);
        bus.iStart = 1'b1;
        bus.iWide  = wide;
        bus.iUseB  = useb;
        bus.iCY    = cy;
        bus.iJ     = j;
        bus.iK     = k;
        @(posedge iClock);
        #1;
        check({tag, ".busy_start"}, 32'(bus.oBusy), 32'd1);
        check({tag, ".done_start"}, 32'(bus.oDone), 32'd0);
        lat = 0;
        while (bus.oDone !== 1'b1 && lat < 10) begin
            bus.iStart = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.iWide  = 1'($urandom_range(0, 1));
            bus.iUseB  = 1'($urandom_range(0, 1));
            bus.iCY    = 1'($urandom_range(0, 1));
            bus.iJ     = 16'($urandom);
            bus.iK     = 16'($urandom);
            @(posedge iClock);
            #1;
            lat++;
        end
        bus.iStart = 1'b0;
        check({tag, ".latency"}, 32'(lat), wide ? 32'd3 : 32'd2);
        check({tag, ".busy_done"}, 32'(bus.oBusy), 32'd0);
        check({tag, ".oD"}, 32'(bus.oD), 32'(exp[23:8]));
        check({tag, ".oF"}, 32'(bus.oF), 32'(exp[7:0]));
    endtask

    task automatic idle_cycle(input string tag);
        logic [15:0] d;
        logic [7:0]  f;
        d = bus.oD;
        f = bus.oF;
        @(posedge iClock);
        #1;
        check({tag, ".idle_done"}, 32'(bus.oDone), 32'd0);
        check({tag, ".idle_busy"}, 32'(bus.oBusy), 32'd0);
        check({tag, ".hold_oD"}, 32'(bus.oD), 32'(d));
        check({tag, ".hold_oF"}, 32'(bus.oF), 32'(f));
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        iReset     = 1'b1;
        bus.iStart = 1'b0;
        bus.iWide  = 1'b0;
        bus.iUseB  = 1'b0;
        bus.iCY    = 1'b0;
        bus.iJ     = 16'h0000;
        bus.iK     = 16'h0000;
        #12;
        check("rst.busy", 32'(bus.oBusy), 32'd0);
        check("rst.done", 32'(bus.oDone), 32'd0);
        check("rst.oD", 32'(bus.oD), 32'h0000);
        check("rst.oF", 32'(bus.oF), 32'h02);
        @(negedge iClock);
        iReset = 1'b0;
        @(posedge iClock);
        #1;

        // Directed vectors with hand-computed flag bytes.
        run_op("sub8", 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0003, 1'b0);
        check("sub8.F_const", 32'(bus.oF), 32'h02);
        idle_cycle("sub8");
        run_op("sbb8_borrow", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0);
        check("sbb8_borrow.F_const", 32'(bus.oF), 32'h97);
        run_op("sbb8_zero", 1'b0, 1'b1, 1'b1, 16'h0010, 16'h000F, 1'b0);
        check("sbb8_zero.F_const", 32'(bus.oF), 32'h56);
        run_op("dsub_chain", 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0001, 1'b0);
        check("dsub_chain.F_const", 32'(bus.oF), 32'h16);
        run_op("dsub_wrap", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1);
        check("dsub_wrap.D_const", 32'(bus.oD), 32'hFFFF);
        idle_cycle("dsub_wrap");
        // 8-bit op must clear a stale high byte; high operand bytes ignored.
        run_op("sub8_clr_hi", 1'b0, 1'b0, 1'b1, 16'hAB40, 16'hCD41, 1'b1);
        check("sub8_clr_hi.D_const", 32'(bus.oD), 32'h00FF);

        // Reset in HI: immediate abort, reset outputs, no done afterwards.
        bus.iStart = 1'b1;
        bus.iWide  = 1'b1;
        bus.iUseB  = 1'b0;
        bus.iCY    = 1'b0;
        bus.iJ     = 16'h1234;
        bus.iK     = 16'h0101;
        @(posedge iClock);
        #1;
        bus.iStart = 1'b0;
        @(posedge iClock);
        #1;
        check("rstmid.busy_hi", 32'(bus.oBusy), 32'd1);
        iReset = 1'b1;
        #1;
        check("rstmid.busy", 32'(bus.oBusy), 32'd0);
        check("rstmid.done", 32'(bus.oDone), 32'd0);
        check("rstmid.oD", 32'(bus.oD), 32'h0000);
        check("rstmid.oF", 32'(bus.oF), 32'h02);
        @(negedge iClock);
        iReset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle_cycle("rstmid");
        end
        run_op("after_rst", 1'b0, 1'b0, 1'b0, 16'h0080, 16'h0001, 1'b0);

        // Random back-to-back operations with random busy-time pokes.
        for (int i = 0; i < 40; i++) begin
            run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
